// File: rtl/booth2_share_ctrl_if.sv
// Bundle of request, multiplier and response channels around the shared Booth2 multiplier.
// slave is the arbiter side; master is the client/multiplier side.
interface booth2_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH-1:0]   req_x;
  logic [N_REQ*WIDTH-1:0]   req_y;
  logic signed [WIDTH-1:0]  mul_x;
  logic signed [WIDTH-1:0]  mul_y;
  logic signed [2*WIDTH-1:0] mul_p;
  logic                     resp_valid;
  logic                     resp_ready;
  logic signed [2*WIDTH-1:0] resp_data;
  logic [ID_W-1:0]          resp_id;

  modport slave (
    input  req_valid, req_x, req_y, mul_p, resp_ready,
    output req_ready, mul_x, mul_y, resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_x, req_y, mul_p, resp_ready,
    input  req_ready, mul_x, mul_y, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/booth2_share_ctrl.sv
// Round-robin time-sharing of one combinational Booth2 multiplier among N_REQ requesters.
// Operands are registered, the product is sampled SETTLE cycles later and returned with its owner's ID.
module booth2_share_ctrl #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2,
  parameter int ID_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  booth2_share_ctrl_if.slave  bus,
  output logic                busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q;
  logic [ID_W-1:0]         ptr_next;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_found;
  logic [CNT_W-1:0]        cnt_q;
  logic                    accept;
  logic signed [WIDTH-1:0] sel_x;
  logic signed [WIDTH-1:0] sel_y;

  // Scan from ptr upward (mod N_REQ); the lowest offset with a valid request wins.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] sel;
    int              idx;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      sel = ID_W'(idx);
      if (valid[sel]) pick = {1'b1, sel};
    end
    return pick;
  endfunction

  always_comb begin
    {gnt_found, gnt_idx} = rr_pick(bus.req_valid, ptr_q);
    accept        = (state_q == IDLE) && gnt_found;
    bus.req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    busy          = (state_q != IDLE);
    ptr_next      = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_x = bus.req_x[i*WIDTH +: WIDTH];
        sel_y = bus.req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage boundary: accept registers operands, WAIT counts down Booth2 settling, DONE holds the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      cnt_q          <= '0;
      bus.mul_x      <= '0;
      bus.mul_y      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
    end else begin
      if (accept) begin
        bus.mul_x   <= sel_x;
        bus.mul_y   <= sel_y;
        bus.resp_id <= gnt_idx;
        ptr_q       <= ptr_next;
        cnt_q       <= CNT_W'(SETTLE - 1);
      end
      if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          bus.resp_data  <= bus.mul_p;
          bus.resp_valid <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
      if ((state_q == DONE) && bus.resp_ready) bus.resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth2_share_ctrl.sv
// Directed and randomized bench for booth2_share_ctrl with a behavioural Booth2 product model.
module tb_booth2_share_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth2_share_ctrl_if #(.N_REQ(4), .WIDTH(32), .ID_W(2)) bus ();

  assign bus.mul_p = $signed({{32{bus.mul_x[31]}}, bus.mul_x}) *
                     $signed({{32{bus.mul_y[31]}}, bus.mul_y});

  booth2_share_ctrl #(.N_REQ(4), .WIDTH(32), .SETTLE(2), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] x, input logic [31:0] y, input logic v);
    bus.req_x[idx*32 +: 32] = x;
    bus.req_y[idx*32 +: 32] = y;
    bus.req_valid[idx]      = v;
  endtask

  task automatic run_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                        output logic signed [63:0] data, output logic [1:0] id, output bit tmo);
    tmo  = 1'b0;
    data = '0;
    id   = '0;
    set_req(idx, x, y, 1'b1);
    #1;
    for (int i = 0; i < 20 && !bus.req_ready[idx]; i++) tick();
    if (!bus.req_ready[idx]) begin
      tmo = 1'b1;
      bus.req_valid[idx] = 1'b0;
      return;
    end
    tick();
    bus.req_valid[idx] = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
    if (!bus.resp_valid) tmo = 1'b1;
    data = bus.resp_data;
    id   = bus.resp_id;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req_ready, bus.mul_x, bus.mul_y, bus.resp_valid, bus.resp_data, bus.resp_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b mx=%h my=%h rv=%b rd=%h id=%0d busy=%b, expected all zero",
               bus.req_ready, bus.mul_x, bus.mul_y, bus.resp_valid, bus.resp_data, bus.resp_id, busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b rv=%b, expected 0 0", busy, bus.resp_valid);
    end
  endtask

  task automatic test_basic();
    logic signed [63:0] d;
    logic [1:0] id;
    bit tmo;
    set_req(0, 32'd3, 32'd5, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL basic_grant0: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if ({bus.req_ready, busy, bus.resp_valid, bus.mul_x, bus.mul_y} !== {4'b0, 1'b1, 1'b0, 32'd3, 32'd5}) begin
      errors++;
      $display("FAIL basic_after_accept: got rdy=%b busy=%b rv=%b mx=%h my=%h, expected 0000 1 0 3 5",
               bus.req_ready, busy, bus.resp_valid, bus.mul_x, bus.mul_y);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.mul_x !== 32'sd3) begin
      errors++;
      $display("FAIL basic_latency_k1: got rv=%b mx=%h, expected rv=0 mx=3", bus.resp_valid, bus.mul_x);
    end
    tick();
    checks++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 64'sd15, 2'd0}) begin
      errors++;
      $display("FAIL basic_resp: got rv=%b data=%h id=%0d, expected 1 15 0",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake: got rv=%b busy=%b, expected 0 0", bus.resp_valid, busy);
    end
    run_op(1, -32'sd7, 32'sd9, d, id, tmo);
    checks++;
    if (tmo || d !== 64'hFFFF_FFFF_FFFF_FFC1 || id !== 2'd1) begin
      errors++;
      $display("FAIL neg_product: got data=%h id=%0d tmo=%b, expected FFFFFFFFFFFFFFC1 1 0", d, id, tmo);
    end
  endtask

  task automatic test_boundary();
    logic signed [63:0] d;
    logic [1:0] id;
    bit tmo;
    run_op(2, 32'h8000_0000, 32'h8000_0000, d, id, tmo);
    checks++;
    if (tmo || d !== 64'h4000_0000_0000_0000 || id !== 2'd2) begin
      errors++;
      $display("FAIL min_times_min: got data=%h id=%0d tmo=%b, expected 4000000000000000 2 0", d, id, tmo);
    end
    run_op(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, d, id, tmo);
    checks++;
    if (tmo || d !== 64'hFFFF_FFFF_8000_0001 || id !== 2'd2) begin
      errors++;
      $display("FAIL max_times_m1: got data=%h id=%0d tmo=%b, expected FFFFFFFF80000001 2 0", d, id, tmo);
    end
  endtask

  task automatic test_round_robin();
    logic signed [63:0] rr_exp [4];
    logic [3:0] eg;
    int last;
    rr_exp[0] = -64'sd200;
    rr_exp[1] = -64'sd600;
    rr_exp[2] = -64'sd1200;
    rr_exp[3] = -64'sd2000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 2), 32'(-(i + 1) * 100), 1'b1);
    bus.resp_ready = 1'b1;
    last = 0;
    #1;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 20 && bus.req_ready == 4'b0; i++) tick();
      eg = 4'b0001 << (n % 4);
      checks++;
      if (bus.req_ready !== eg) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b expected %b", n, bus.req_ready, eg);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last !== 4) begin
          errors++;
          $display("FAIL rr_spacing_%0d: got %0d cycles expected 4", n, cyc - last);
        end
      end
      last = cyc;
      tick();
      for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
      checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'(n % 4), rr_exp[n % 4]}) begin
        errors++;
        $display("FAIL rr_resp_%0d: got rv=%b id=%0d data=%h expected 1 %0d %h",
                 n, bus.resp_valid, bus.resp_id, bus.resp_data, n % 4, rr_exp[n % 4]);
      end
      if (n == 7) bus.req_valid = '0;
      tick();
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_req(3, -32'sd5, 32'sd6, 1'b1);
    #1;
    for (int i = 0; i < 20 && !bus.req_ready[3]; i++) tick();
    tick();
    bus.req_valid[3] = 1'b0;
    set_req(0, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.resp_valid, busy, bus.req_ready, bus.resp_id, bus.resp_data} !==
          {1'b1, 1'b1, 4'b0, 2'd3, -64'sd30}) begin
        errors++;
        $display("FAIL hold_done_%0d: got rv=%b busy=%b rdy=%b id=%0d data=%h expected 1 1 0000 3 -30",
                 i, bus.resp_valid, busy, bus.req_ready, bus.resp_id, bus.resp_data);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.resp_valid, busy, bus.req_ready} !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL release_idle: got rv=%b busy=%b rdy=%b expected 0 0 0001",
               bus.resp_valid, busy, bus.req_ready);
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req(1, 32'd11, 32'd13, 1'b1);
    #1;
    for (int i = 0; i < 20 && !bus.req_ready[1]; i++) tick();
    tick();
    bus.req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_wait: got busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus.resp_valid, busy, bus.req_ready, bus.resp_id, bus.mul_x, bus.mul_y, bus.resp_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_vals: got rv=%b busy=%b rdy=%b id=%0d mx=%h my=%h rd=%h expected all zero",
               bus.resp_valid, busy, bus.req_ready, bus.resp_id, bus.mul_x, bus.mul_y, bus.resp_data);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_resp_%0d: got rv=%b expected 0", i, bus.resp_valid);
      end
    end
    set_req(0, 32'd2, 32'd3, 1'b1);
    set_req(1, 32'd11, 32'd13, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ptr_zero: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.resp_valid; i++) tick();
    checks++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 2'd0, 64'sd6}) begin
      errors++;
      $display("FAIL mid_next_op: got rv=%b id=%0d data=%h expected 1 0 6",
               bus.resp_valid, bus.resp_id, bus.resp_data);
    end
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic signed [63:0] d, e;
    logic [31:0] x, y;
    logic [1:0] id, eid;
    bit tmo;
    int idx;
    for (int n = 0; n < 10000; n++) begin
      idx = $urandom_range(0, 3);
      x = $urandom;
      y = $urandom;
      if (n % 16 == 0) x = 32'h8000_0000;
      if (n % 24 == 5) y = 32'hFFFF_FFFF;
      eid = 2'(idx);
      e = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      run_op(idx, x, y, d, id, tmo);
      checks++;
      if (tmo || d !== e || id !== eid) begin
        errors++;
        $display("FAIL rand_%0d: got data=%h id=%0d tmo=%b expected %h %0d 0", n, d, id, tmo, e, eid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
